// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: shares the CPU's single interrupt line among four level-triggered sources
//   Sources are timer (0), mouse (1), IR (2) and spare (3). The block grants one enabled
//   request, presents it to the CPU, and routes the CPU ack back to that source only.
//   Bus window at ArbBaseAddr: +0 status (RO), +1 mask (RW), +2 grant count (RW, any write clears).
//   Optional feature: define ARB_ROUND_ROBIN_EN for rotating priority (default: fixed, timer first).
// Ports:
//   CLK            system clock
//   RESET          synchronous, active-high reset
//   BUS_DATA       shared 8-bit data bus; driven only during the cycle after a read hit
//   BUS_ADDR       bus address
//   BUS_WE         bus write enable
//   SRC_RAISE      level requests, bit 0 = timer
//   SRC_ACK        one-cycle ack pulse to the granted source
//   CPU_INT_RAISE  interrupt request to the CPU
//   CPU_INT_ID     granted source index, valid while CPU_INT_RAISE is high
//   CPU_INT_ACK    one-cycle ack from the CPU
module interrupt_arbiter #(
   parameter logic [7:0] ArbBaseAddr   = 8'hE0,
   parameter logic [3:0] InitialMask   = 4'hF,
   parameter int         HoldoffCycles = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   inout  wire  [7:0] BUS_DATA,
   input  logic [7:0] BUS_ADDR,
   input  logic       BUS_WE,
   input  logic [3:0] SRC_RAISE,
   output logic [3:0] SRC_ACK,
   output logic       CPU_INT_RAISE,
   output logic [1:0] CPU_INT_ID,
   input  logic       CPU_INT_ACK
);
   typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} state_t;
   state_t     state, state_nxt;
   logic [3:0] mask, mask_nxt, req, hold;
   logic [7:0] count, rd_data;
   logic [1:0] win;
   logic       sel_stat, sel_mask, sel_cnt, rd_en, grant, acked;
   assign sel_stat = BUS_ADDR == ArbBaseAddr;
   assign sel_mask = BUS_ADDR == ArbBaseAddr + 8'd1;
   assign sel_cnt  = BUS_ADDR == ArbBaseAddr + 8'd2;
   assign req      = SRC_RAISE & mask;
   // withdraw looks at the mask being written this cycle so the request drops one cycle after the write
   assign mask_nxt = (sel_mask & BUS_WE) ? BUS_DATA[3:0] : mask;
   assign CPU_INT_RAISE = state == WAIT_ACK;
   assign BUS_DATA = rd_en ? rd_data : 8'hzz;
`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] ptr;
   always_ff @(posedge CLK)
      ptr <= RESET ? 2'd0 : acked ? CPU_INT_ID + 2'd1 : ptr;
   // scan offsets high to low so the closest set bit after ptr is the one that sticks
   always_comb begin
      win = ptr;
      for (int i = 3; i >= 0; i--)
         if (req[ptr + 2'(i)]) win = ptr + 2'(i);
   end
`else
   always_comb begin
      win = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (req[i]) win = 2'(i);
   end
`endif
   always_ff @(posedge CLK)
      state <= RESET ? IDLE : state_nxt;
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      acked     = 1'b0;
      case (state)
         IDLE:
            if (|req) begin
               state_nxt = WAIT_ACK;
               grant     = 1'b1;
            end
         WAIT_ACK:
            if (CPU_INT_ACK) begin
               state_nxt = RELEASE;
               acked     = 1'b1;
            end else if (!mask_nxt[CPU_INT_ID]) state_nxt = IDLE;
         RELEASE:
            if (hold == 4'd0) state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         mask       <= InitialMask;
         count      <= 8'd0;
         CPU_INT_ID <= 2'd0;
         SRC_ACK    <= 4'd0;
         hold       <= 4'd0;
         rd_en      <= 1'b0;
         rd_data    <= 8'd0;
      end else begin
         mask       <= mask_nxt;
         count      <= (sel_cnt & BUS_WE) ? 8'd0 : count + {7'd0, acked};
         CPU_INT_ID <= grant ? win : CPU_INT_ID;
         SRC_ACK    <= acked ? 4'b0001 << CPU_INT_ID : 4'b0000;
         // counts down the remaining RELEASE cycles; reloaded on every ack
         hold       <= acked ? 4'(HoldoffCycles - 1) : (state == RELEASE) ? hold - 4'd1 : hold;
         rd_en      <= !BUS_WE & (sel_stat | sel_mask | sel_cnt);
         rd_data    <= sel_stat ? {state != IDLE, 1'b0, CPU_INT_ID, req} : sel_mask ? {4'd0, mask} : count;
      end
   end
endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb_interrupt_arbiter: directed bench with a behavioural model for interrupt_arbiter
module tb_interrupt_arbiter;
   localparam int HOLD = 2;
   logic       CLK = 1'b0, RESET = 1'b1, BUS_WE = 1'b0, CPU_INT_ACK = 1'b0, drv_en = 1'b0;
   logic [7:0] BUS_ADDR = 8'h00, drv = 8'h00;
   logic [3:0] SRC_RAISE = 4'h0;
   wire  [7:0] BUS_DATA;
   wire  [3:0] SRC_ACK;
   wire        CPU_INT_RAISE;
   wire  [1:0] CPU_INT_ID;
   int         n_chk = 0, n_err = 0;
   assign BUS_DATA = drv_en ? drv : 8'hzz;
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (BUS_DATA[g]);
   end
   always #5 CLK = ~CLK;
   interrupt_arbiter dut (
      .CLK(CLK), .RESET(RESET), .BUS_DATA(BUS_DATA), .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE),
      .SRC_RAISE(SRC_RAISE), .SRC_ACK(SRC_ACK), .CPU_INT_RAISE(CPU_INT_RAISE),
      .CPU_INT_ID(CPU_INT_ID), .CPU_INT_ACK(CPU_INT_ACK)
   );
   // model: phase 0 idle, 1 granted, 2 holdoff
   int         m_phase = 0, m_hold = 0;
   logic [1:0] m_id = 0;
   logic [3:0] m_mask = 4'hF, m_ack = 0;
   logic [7:0] m_cnt = 0, m_rd_val = 0;
   logic       m_rd_valid = 0;
`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] m_ptr = 0;
`endif
   function automatic logic [1:0] pick(input logic [3:0] r);
      for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (r[(int'(m_ptr) + k) % 4]) return 2'((int'(m_ptr) + k) % 4);
`else
         if (r[k]) return 2'(k);
`endif
      end
      return 2'd0;
   endfunction
   always @(posedge CLK) begin : mdl
      logic [3:0] r, nm;
      logic       wr, inc;
      if (RESET) begin
         m_phase = 0; m_hold = 0; m_id = 0; m_mask = 4'hF; m_ack = 0; m_cnt = 0; m_rd_valid = 0;
`ifdef ARB_ROUND_ROBIN_EN
         m_ptr = 0;
`endif
      end else begin
         r  = SRC_RAISE & m_mask;
         wr = BUS_WE && drv_en;
         nm = (wr && BUS_ADDR == 8'hE1) ? drv[3:0] : m_mask;
         m_rd_valid = !BUS_WE && BUS_ADDR >= 8'hE0 && BUS_ADDR <= 8'hE2;
         m_rd_val = (BUS_ADDR == 8'hE0) ? {m_phase != 0, 1'b0, m_id, r} :
                    (BUS_ADDR == 8'hE1) ? {4'h0, m_mask} : m_cnt;
         m_ack = 0;
         inc = 0;
         if (m_phase == 0) begin
            if (r != 0) begin m_id = pick(r); m_phase = 1; end
         end else if (m_phase == 1) begin
            if (CPU_INT_ACK) begin
               m_ack = 4'b0001 << m_id; inc = 1; m_phase = 2; m_hold = HOLD;
`ifdef ARB_ROUND_ROBIN_EN
               m_ptr = m_id + 2'd1;
`endif
            end else if (!nm[m_id]) m_phase = 0;
         end else begin
            m_hold--;
            if (m_hold == 0) m_phase = 0;
         end
         m_cnt = (wr && BUS_ADDR == 8'hE2) ? 8'd0 : m_cnt + {7'd0, inc};
         m_mask = nm;
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // one clock, then compare every output against the model mid-cycle
   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
      chk("raise", CPU_INT_RAISE, m_phase == 1);
      if (m_phase == 1) chk("id", CPU_INT_ID, m_id);
      chk("src_ack", SRC_ACK, m_ack);
      if (!drv_en) chk("bus", BUS_DATA, m_rd_valid ? m_rd_val : 8'hFF);
   endtask
   task automatic wait_grant(output logic [1:0] id, output int t);
      t = 0;
      while (!CPU_INT_RAISE && t < 20) begin step(); t++; end
      chk("grant_timeout", CPU_INT_RAISE, 1'b1);
      id = CPU_INT_ID;
   endtask
   task automatic grant_ack(output logic [1:0] id, output int t);
      wait_grant(id, t);
      CPU_INT_ACK = 1'b1;
      step();
      CPU_INT_ACK = 1'b0;
   endtask
   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      BUS_ADDR = a; BUS_WE = 1'b1; drv = d; drv_en = 1'b1;
      step();
      BUS_ADDR = 8'h00; BUS_WE = 1'b0; drv_en = 1'b0;
   endtask
   task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
      BUS_ADDR = a;
      step();
      BUS_ADDR = 8'h00;
      chk(name, BUS_DATA, exp);
      step();
   endtask
   task automatic do_reset();
      RESET = 1'b1; step(); step(); RESET = 1'b0; step();
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   initial begin
      logic [1:0] id;
      int t;
      RESET = 1'b1; step(); step();
      chk("rst_raise", CPU_INT_RAISE, 1'b0);
      chk("rst_srcack", SRC_ACK, 4'h0);
      chk("rst_id", CPU_INT_ID, 2'd0);
      chk("rst_bus", BUS_DATA, 8'hFF);
      RESET = 1'b0; step();
      rd(8'hE1, 8'h0F, "rst_mask");
      rd(8'hE2, 8'h00, "rst_count");
      // single timer request
      SRC_RAISE = 4'b0001; step();
      chk("t1_raise", CPU_INT_RAISE, 1'b1);
      chk("t1_id", CPU_INT_ID, 2'd0);
      CPU_INT_ACK = 1'b1; step(); CPU_INT_ACK = 1'b0;
      chk("t1_srcack", SRC_ACK, 4'b0001);
      chk("t1_drop", CPU_INT_RAISE, 1'b0);
      SRC_RAISE = 4'b0000; step();
      chk("t1_ackpulse", SRC_ACK, 4'b0000);
      idle(2);
      rd(8'hE2, 8'h01, "t1_count");
      rd(8'hF3, 8'hFF, "t1_undecoded");
      // 4'b1010 held: fixed gives 1,1,1; rotating (ptr=1) gives 1,3,1
      SRC_RAISE = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         grant_ack(id, t);
`ifdef ARB_ROUND_ROBIN_EN
         chk("t2_id", id, (i == 1) ? 2'd3 : 2'd1);
`else
         chk("t2_id", id, 2'd1);
`endif
         if (i > 0) chk("t2_gap", t, HOLD + 1);
      end
      SRC_RAISE = 4'b0000; idle(4);
      // all four requesting
      do_reset();
      SRC_RAISE = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         grant_ack(id, t);
`ifdef ARB_ROUND_ROBIN_EN
         chk("t3_id", id, 2'(i % 4));
`else
         chk("t3_id", id, 2'd0);
`endif
      end
      SRC_RAISE = 4'b0000; idle(4);
      // withdraw by masking, then ack racing the mask write
      do_reset();
      SRC_RAISE = 4'b0100;
      wait_grant(id, t);
      chk("t4_id", id, 2'd2);
      wr(8'hE1, 8'h0B);
      chk("t4_withdraw", CPU_INT_RAISE, 1'b0);
      chk("t4_noack", SRC_ACK, 4'h0);
      step();
      chk("t4_noack2", SRC_ACK, 4'h0);
      rd(8'hE2, 8'h00, "t4_count_same");
      SRC_RAISE = 4'b0000;
      wr(8'hE1, 8'h0F);
      SRC_RAISE = 4'b0100;
      wait_grant(id, t);
      BUS_ADDR = 8'hE1; BUS_WE = 1'b1; drv = 8'h0B; drv_en = 1'b1; CPU_INT_ACK = 1'b1;
      step();
      BUS_ADDR = 8'h00; BUS_WE = 1'b0; drv_en = 1'b0; CPU_INT_ACK = 1'b0;
      chk("t4_ackwins", SRC_ACK, 4'b0100);
      chk("t4_ackdrop", CPU_INT_RAISE, 1'b0);
      SRC_RAISE = 4'b0000; idle(3);
      rd(8'hE2, 8'h01, "t4_count_inc");
      rd(8'hE1, 8'h0B, "t4_mask");
      wr(8'hE1, 8'h0F);
      // count wrap and clear-beats-increment
      do_reset();
      SRC_RAISE = 4'b0001;
      for (int i = 0; i < 255; i++) grant_ack(id, t);
      SRC_RAISE = 4'b0000; idle(3);
      rd(8'hE2, 8'hFF, "t5_count255");
      SRC_RAISE = 4'b0001; grant_ack(id, t);
      SRC_RAISE = 4'b0000; idle(3);
      rd(8'hE2, 8'h00, "t5_wrap");
      SRC_RAISE = 4'b0001; grant_ack(id, t);
      wait_grant(id, t);
      BUS_ADDR = 8'hE2; BUS_WE = 1'b1; drv = 8'h55; drv_en = 1'b1; CPU_INT_ACK = 1'b1;
      step();
      BUS_ADDR = 8'h00; BUS_WE = 1'b0; drv_en = 1'b0; CPU_INT_ACK = 1'b0;
      SRC_RAISE = 4'b0000; idle(3);
      rd(8'hE2, 8'h00, "t5_clear_wins");
      // status readback while busy
      do_reset();
      SRC_RAISE = 4'b0011;
      wait_grant(id, t);
      rd(8'hE0, 8'h83, "t6_status");
      chk("t6_z", BUS_DATA, 8'hFF);
      // reset while waiting for ack
      RESET = 1'b1; CPU_INT_ACK = 1'b1; step();
      chk("t7_raise", CPU_INT_RAISE, 1'b0);
      chk("t7_srcack", SRC_ACK, 4'h0);
      chk("t7_id", CPU_INT_ID, 2'd0);
      RESET = 1'b0; CPU_INT_ACK = 1'b0; SRC_RAISE = 4'b0000; step();
      chk("t7_srcack2", SRC_ACK, 4'h0);
      rd(8'hE1, 8'h0F, "t7_mask");
      rd(8'hE2, 8'h00, "t7_count");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
